// File: rtl/data_memory_sized.sv
// Sized MIPS data memory: byte-lane stores, extended registered loads (1-cycle latency),
// range/alignment checking against BASE_ADDR with a pulsed and a sticky error status.
module data_memory_sized #(
   parameter int unsigned           MEMORY_DEPTH = 1024,
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemWrite,
   input  logic                  MemRead,
   input  logic [1:0]            Size,
   input  logic                  Unsigned,
   input  logic [ADDR_WIDTH-1:0] Address,
   input  logic [31:0]           WriteData,
   output logic [31:0]           ReadData,
   output logic                  ReadValid,
   output logic                  AccessError,
   output logic                  ErrorSticky,
   output logic [ADDR_WIDTH-1:0] ErrorAddr
);

   localparam int unsigned IDX_W = $clog2(MEMORY_DEPTH);

   logic [31:0]           r_mem [MEMORY_DEPTH];

   logic [ADDR_WIDTH-1:0] w_offset;
   logic [IDX_W-1:0]      w_idx;
   logic [1:0]            w_lane;
   logic                  w_below;
   logic                  w_oor;
   logic                  w_misaligned;
   logic                  w_illegal;
   logic                  w_fault;
   logic [3:0]            w_be;
   logic [31:0]           w_wlanes;
   logic [31:0]           w_rword;
   logic [31:0]           w_rshift;
   logic [31:0]           w_load;

   // Unsigned offset; an address below the base wraps high and is caught by w_below.
   assign w_offset = Address - BASE_ADDR;
   assign w_below  = (Address < BASE_ADDR);
   assign w_idx    = w_offset[IDX_W+1:2];
   assign w_lane   = w_offset[1:0];
   assign w_oor    = w_below || (w_offset[ADDR_WIDTH-1:IDX_W+2] != '0);

   always_comb begin
      w_misaligned = 1'b0;
      w_illegal    = 1'b0;
      w_be         = '0;
      w_wlanes     = WriteData;
      case (Size)
         2'b00: begin
            w_be     = 4'b0001 << w_lane;
            w_wlanes = {4{WriteData[7:0]}};
         end
         2'b01: begin
            w_misaligned = w_lane[0];
            w_be         = 4'b0011 << w_lane;
            w_wlanes     = {2{WriteData[15:0]}};
         end
         2'b10: begin
            w_misaligned = (w_lane != 2'b00);
            w_be         = 4'b1111;
         end
         default: w_illegal = 1'b1;
      endcase
   end

   assign w_fault = (MemRead || MemWrite) && (w_oor || w_misaligned || w_illegal);

   // Combinational read of the pre-edge word gives read-before-write on a shared access.
   assign w_rword  = r_mem[w_idx];
   assign w_rshift = w_rword >> {w_lane, 3'b000};

   always_comb begin
      w_load = w_rshift;
      case (Size)
         2'b00:   w_load = {{24{~Unsigned & w_rshift[7]}},  w_rshift[7:0]};
         2'b01:   w_load = {{16{~Unsigned & w_rshift[15]}}, w_rshift[15:0]};
         default: w_load = w_rshift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (MemWrite && !w_fault) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ReadData    <= '0;
         ReadValid   <= 1'b0;
         AccessError <= 1'b0;
         ErrorSticky <= 1'b0;
         ErrorAddr   <= '0;
      end else begin
         ReadValid   <= MemRead;
         AccessError <= w_fault;
         if (MemRead) ReadData <= w_fault ? '0 : w_load;
         if (w_fault) begin
            ErrorSticky <= 1'b1;
            ErrorAddr   <= Address;
         end
      end
   end

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: directed scenarios plus randomized traffic checked
// against a byte-array reference model of the memory and its error reporting.
module tb_data_memory_sized;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned AW    = 32;
   localparam logic [31:0] BASE  = 32'h1001_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          MemWrite, MemRead, Unsigned;
   logic [1:0]    Size;
   logic [AW-1:0] Address;
   logic [31:0]   WriteData;
   logic [31:0]   ReadData;
   logic          ReadValid, AccessError, ErrorSticky;
   logic [AW-1:0] ErrorAddr;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   bit [7:0]    m_mem [4*DEPTH];
   logic [31:0] exp_rd;
   logic        exp_rv, exp_err, exp_sticky;
   logic [31:0] exp_eaddr;

   data_memory_sized #(
      .MEMORY_DEPTH (DEPTH),
      .ADDR_WIDTH   (AW),
      .BASE_ADDR    (BASE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .MemWrite    (MemWrite),
      .MemRead     (MemRead),
      .Size        (Size),
      .Unsigned    (Unsigned),
      .Address     (Address),
      .WriteData   (WriteData),
      .ReadData    (ReadData),
      .ReadValid   (ReadValid),
      .AccessError (AccessError),
      .ErrorSticky (ErrorSticky),
      .ErrorAddr   (ErrorAddr)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: time limit reached, summary not printed");
      $fatal(1);
   end

   task automatic model_reset();
      exp_rd = '0; exp_rv = 1'b0; exp_err = 1'b0; exp_sticky = 1'b0; exp_eaddr = '0;
   endtask

   // Reference: byte-addressed little-endian memory, faults decided from plain arithmetic.
   task automatic model_step(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd);
      longint off    = longint'(addr) - longint'(BASE);
      int     nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      bit     fault;
      longint v;
      logic [31:0] wtmp;
      fault = (rd || wr) && (off < 0 || off >= 4*DEPTH || sz == 2'd3 ||
                             (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off % 4 != 0));
      if (rd) begin
         if (fault) exp_rd = '0;
         else begin
            v = 0;
            for (int i = 0; i < nbytes; i++) v += longint'(m_mem[off+i]) << (8*i);
            if (!uns && v >= (64'sd1 << (8*nbytes-1))) v -= (64'sd1 << (8*nbytes));
            exp_rd = v[31:0];
         end
      end
      exp_rv  = rd;
      exp_err = fault;
      if (fault) begin
         exp_sticky = 1'b1;
         exp_eaddr  = addr;
      end
      if (wr && !fault) begin
         wtmp = wd;
         for (int i = 0; i < nbytes; i++) begin
            m_mem[off+i] = wtmp[7:0];
            wtmp = wtmp >> 8;
         end
      end
   endtask

   // Drives one request, advances past the edge and updates the model in step.
   task automatic apply(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd);
      MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns; Address = addr; WriteData = wd;
      model_step(rd, wr, sz, uns, addr, wd);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      apply(1'b0, 1'b0, 2'd2, 1'b0, BASE, 32'h0);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      MemRead = 1'b0; MemWrite = 1'b0; Size = 2'd2; Unsigned = 1'b0; Address = BASE; WriteData = '0;
      model_reset();
      #1;
      n_vec++; if (ReadData !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", ReadData); end
      n_vec++; if (ReadValid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", ReadValid); end
      n_vec++; if (AccessError !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", AccessError); end
      n_vec++; if (ErrorSticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky: got %b want 0", ErrorSticky); end
      n_vec++; if (ErrorAddr !== 32'h0) begin n_err++; $display("FAIL reset_eaddr: got %h want 0", ErrorAddr); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int unsigned w = 0; w < DEPTH; w++) apply(1'b0, 1'b1, 2'd2, 1'b0, BASE + 4*w, 32'h0);
      idle();
   endtask

   task automatic test_word();
      apply(1'b0, 1'b1, 2'd2, 1'b0, BASE, 32'hDEAD_BEEF);
      apply(1'b1, 1'b0, 2'd2, 1'b0, BASE, 32'h0);
      n_vec++; if (ReadData !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL word_load: got %h want DEADBEEF", ReadData); end
      n_vec++; if (ReadValid !== 1'b1) begin n_err++; $display("FAIL word_valid: got %b want 1", ReadValid); end
      idle();
      n_vec++; if (ReadValid !== 1'b0) begin n_err++; $display("FAIL word_valid_drop: got %b want 0", ReadValid); end
      n_vec++; if (ReadData !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL word_hold: got %h want DEADBEEF", ReadData); end
   endtask

   task automatic test_byte();
      apply(1'b0, 1'b1, 2'd0, 1'b0, BASE + 6, 32'hABCD_EF80);
      apply(1'b1, 1'b0, 2'd0, 1'b0, BASE + 6, 32'h0);
      n_vec++; if (ReadData !== 32'hFFFF_FF80) begin n_err++; $display("FAIL byte_signed: got %h want FFFFFF80", ReadData); end
      apply(1'b1, 1'b0, 2'd0, 1'b1, BASE + 6, 32'h0);
      n_vec++; if (ReadData !== 32'h0000_0080) begin n_err++; $display("FAIL byte_unsigned: got %h want 00000080", ReadData); end
      apply(1'b1, 1'b0, 2'd2, 1'b0, BASE + 4, 32'h0);
      n_vec++; if (ReadData !== 32'h0080_0000) begin n_err++; $display("FAIL byte_lane: got %h want 00800000", ReadData); end
   endtask

   task automatic test_half();
      apply(1'b0, 1'b1, 2'd1, 1'b0, BASE + 32'hA, 32'h1234_8001);
      apply(1'b1, 1'b0, 2'd1, 1'b0, BASE + 32'hA, 32'h0);
      n_vec++; if (ReadData !== 32'hFFFF_8001) begin n_err++; $display("FAIL half_signed: got %h want FFFF8001", ReadData); end
      n_vec++; if (AccessError !== 1'b0) begin n_err++; $display("FAIL half_noerr: got %b want 0", AccessError); end
      apply(1'b1, 1'b0, 2'd1, 1'b0, BASE + 32'h9, 32'h0);
      n_vec++; if (ReadData !== 32'h0) begin n_err++; $display("FAIL half_mis_data: got %h want 0", ReadData); end
      n_vec++; if (ReadValid !== 1'b1) begin n_err++; $display("FAIL half_mis_valid: got %b want 1", ReadValid); end
      n_vec++; if (AccessError !== 1'b1) begin n_err++; $display("FAIL half_mis_err: got %b want 1", AccessError); end
      n_vec++; if (ErrorSticky !== 1'b1) begin n_err++; $display("FAIL half_mis_sticky: got %b want 1", ErrorSticky); end
      n_vec++; if (ErrorAddr !== 32'h1001_0009) begin n_err++; $display("FAIL half_mis_eaddr: got %h want 10010009", ErrorAddr); end
      idle();
      n_vec++; if (AccessError !== 1'b0) begin n_err++; $display("FAIL err_pulse: got %b want 0", AccessError); end
      n_vec++; if (ErrorSticky !== 1'b1) begin n_err++; $display("FAIL sticky_hold: got %b want 1", ErrorSticky); end
      apply(1'b0, 1'b1, 2'd2, 1'b0, BASE + 32'h2, 32'hFFFF_FFFF);
      n_vec++; if (AccessError !== 1'b1) begin n_err++; $display("FAIL mis_store_err: got %b want 1", AccessError); end
      apply(1'b1, 1'b0, 2'd2, 1'b0, BASE, 32'h0);
      n_vec++; if (ReadData !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mis_store_ram: got %h want DEADBEEF", ReadData); end
      apply(1'b1, 1'b0, 2'd3, 1'b0, BASE, 32'h0);
      n_vec++; if (AccessError !== 1'b1 || ReadData !== 32'h0) begin n_err++; $display("FAIL size_illegal: err=%b data=%h want err=1 data=0", AccessError, ReadData); end
   endtask

   task automatic test_range();
      apply(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000_FFFC, 32'h0);
      n_vec++; if (AccessError !== 1'b1) begin n_err++; $display("FAIL below_err: got %b want 1", AccessError); end
      n_vec++; if (ErrorAddr !== 32'h1000_FFFC) begin n_err++; $display("FAIL below_eaddr: got %h want 1000FFFC", ErrorAddr); end
      apply(1'b1, 1'b0, 2'd2, 1'b0, BASE + 4*DEPTH, 32'h0);
      n_vec++; if (AccessError !== 1'b1) begin n_err++; $display("FAIL above_err: got %b want 1", AccessError); end
      n_vec++; if (ErrorAddr !== 32'h1001_1000) begin n_err++; $display("FAIL above_eaddr: got %h want 10011000", ErrorAddr); end
      apply(1'b0, 1'b1, 2'd2, 1'b0, 32'h1000_FFFC, 32'h5555_5555);
      apply(1'b0, 1'b1, 2'd2, 1'b0, BASE + 4*DEPTH, 32'h5555_5555);
      apply(1'b1, 1'b0, 2'd2, 1'b0, BASE, 32'h0);
      n_vec++; if (ReadData !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL oor_word0: got %h want DEADBEEF", ReadData); end
      apply(1'b1, 1'b0, 2'd2, 1'b0, BASE + 4*(DEPTH-1), 32'h0);
      n_vec++; if (ReadData !== 32'h0 || AccessError !== 1'b0) begin n_err++; $display("FAIL oor_lastword: data=%h err=%b want 0/0", ReadData, AccessError); end
   endtask

   task automatic test_rw_same();
      apply(1'b0, 1'b1, 2'd2, 1'b0, BASE + 32'h10, 32'h1111_1111);
      apply(1'b1, 1'b1, 2'd2, 1'b0, BASE + 32'h10, 32'h2222_2222);
      n_vec++; if (ReadData !== 32'h1111_1111) begin n_err++; $display("FAIL rw_old: got %h want 11111111", ReadData); end
      apply(1'b1, 1'b0, 2'd2, 1'b0, BASE + 32'h10, 32'h0);
      n_vec++; if (ReadData !== 32'h2222_2222) begin n_err++; $display("FAIL rw_new: got %h want 22222222", ReadData); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [8];
      for (int i = 0; i < 8; i++) begin
         d[i] = $urandom;
         apply(1'b0, 1'b1, 2'd2, 1'b0, BASE + 32'h40 + 4*i, d[i]);
      end
      for (int i = 0; i < 8; i++) begin
         apply(1'b1, 1'b0, 2'd2, 1'b0, BASE + 32'h40 + 4*i, 32'h0);
         n_vec++; if (ReadValid !== 1'b1 || ReadData !== d[i]) begin n_err++; $display("FAIL stream[%0d]: valid=%b data=%h want 1/%h", i, ReadValid, ReadData, d[i]); end
      end
   endtask

   task automatic test_random();
      logic        rd, wr, uns;
      logic [1:0]  sz;
      logic [31:0] addr;
      int unsigned sel;
      for (int n = 0; n < 300; n++) begin
         rd  = $urandom_range(0, 1);
         wr  = $urandom_range(0, 1);
         uns = $urandom_range(0, 1);
         sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         sel = $urandom_range(0, 9);
         if (sel == 0)      addr = BASE - $urandom_range(1, 16);
         else if (sel == 1) addr = BASE + 4*DEPTH + $urandom_range(0, 16);
         else               addr = BASE + $urandom_range(0, 4*DEPTH-1);
         if ($urandom_range(0, 3) != 0 && sz == 2'd1) addr[0] = 1'b0;
         if ($urandom_range(0, 3) != 0 && sz == 2'd2) addr[1:0] = 2'b00;
         apply(rd, wr, sz, uns, addr, $urandom);
         n_vec++; if (ReadData !== exp_rd) begin n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, ReadData, exp_rd); end
         n_vec++; if (ReadValid !== exp_rv) begin n_err++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", n, ReadValid, exp_rv); end
         n_vec++; if (AccessError !== exp_err) begin n_err++; $display("FAIL rnd_err[%0d]: got %b want %b", n, AccessError, exp_err); end
         n_vec++; if (ErrorSticky !== exp_sticky) begin n_err++; $display("FAIL rnd_sticky[%0d]: got %b want %b", n, ErrorSticky, exp_sticky); end
         n_vec++; if (ErrorAddr !== exp_eaddr) begin n_err++; $display("FAIL rnd_eaddr[%0d]: got %h want %h", n, ErrorAddr, exp_eaddr); end
      end
   endtask

   task automatic test_reset_midload();
      apply(1'b0, 1'b1, 2'd2, 1'b0, BASE + 32'h20, 32'hCAFE_F00D);
      apply(1'b1, 1'b0, 2'd3, 1'b0, BASE, 32'h0);
      n_vec++; if (ErrorSticky !== 1'b1) begin n_err++; $display("FAIL pre_reset_sticky: got %b want 1", ErrorSticky); end
      MemRead = 1'b1; MemWrite = 1'b0; Size = 2'd2; Address = BASE + 32'h20;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      n_vec++; if (ErrorSticky !== 1'b0) begin n_err++; $display("FAIL async_sticky: got %b want 0", ErrorSticky); end
      n_vec++; if (ReadValid !== 1'b0) begin n_err++; $display("FAIL async_rvalid: got %b want 0", ReadValid); end
      @(posedge clk);
      #1;
      n_vec++; if (ReadValid !== 1'b0) begin n_err++; $display("FAIL midload_rvalid: got %b want 0", ReadValid); end
      n_vec++; if (ReadData !== 32'h0) begin n_err++; $display("FAIL midload_rdata: got %h want 0", ReadData); end
      n_vec++; if (AccessError !== 1'b0 || ErrorAddr !== 32'h0) begin n_err++; $display("FAIL midload_err: err=%b eaddr=%h want 0/0", AccessError, ErrorAddr); end
      MemRead = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      apply(1'b1, 1'b0, 2'd2, 1'b0, BASE + 32'h20, 32'h0);
      n_vec++; if (ReadData !== 32'hCAFE_F00D || ReadValid !== 1'b1) begin n_err++; $display("FAIL post_reset_load: data=%h valid=%b want CAFEF00D/1", ReadData, ReadValid); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_range();
      test_rw_same();
      test_back_to_back();
      test_random();
      test_reset_midload();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
Next-generation data memory for the MIPS pipeline MEM stage. Word-organised RAM with byte/halfword/word stores via byte lanes. Loads are sized, sign- or zero-extended and registered, with 1-cycle latency and a valid flag. Accesses are address-range checked and alignment checked against a configurable data-segment base, and a sticky error status is reported.

Parameters:
MEMORY_DEPTH, 1024, number of 32-bit words (power of 2)
BASE_ADDR, 32'h1001_0000, byte address mapped to word 0
ADDR_WIDTH, 32, byte-address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
MemWrite  input  1  store request this cycle
MemRead  input  1  load request this cycle
Size  input  2  00 byte, 01 half, 10 word, 11 illegal
Unsigned  input  1  1 = zero-extend sub-word load, 0 = sign-extend
Address  input  ADDR_WIDTH  byte address
WriteData  input  32  store data; sub-word data taken from low bits
ReadData  output  32  registered, extended load result
ReadValid  output  1  1-cycle pulse, ReadData updated this cycle
AccessError  output  1  1-cycle pulse: previous request was misaligned, out of range or illegal Size
ErrorSticky  output  1  set on any AccessError, cleared only by reset
ErrorAddr  output  ADDR_WIDTH  Address of the most recent faulting access

Behaviour:
- Reset (reset=0, async): ReadData=0, ReadValid=0, AccessError=0, ErrorSticky=0, ErrorAddr=0. RAM contents are not cleared.
- Offset = Address - BASE_ADDR. Word index = Offset[..:2]. Lane = Offset[1:0].
- The access is out of range if Address < BASE_ADDR or word index >= MEMORY_DEPTH.
- Misaligned cases: half with Lane[0]=1; word with Lane!=00. Size=11 is illegal.
- A request is faulting if MemRead or MemWrite is 1 and any of the three conditions holds.
- Store, non-faulting: on the clk edge, only the addressed lanes are written.
  - Byte: lane L <= WriteData[7:0].
  - Half: lanes L..L+1 <= WriteData[15:0].
  - Word: all lanes written.
  - Little-endian: lane 0 = bits [7:0].
- Faulting store: RAM unchanged.
- Load, non-faulting: at the edge, the RAM word is read and the selected byte/half is extracted and extended per Unsigned. The result goes to ReadData with ReadValid=1 in the following cycle (latency 1).
- Faulting load: ReadData <= 0, ReadValid=1.
- ReadData holds its value when there is no load. ReadValid=0 on cycles after no load.
- Fault reporting: AccessError=1 for exactly the cycle after the faulting request. ErrorSticky <= 1 and ErrorAddr <= Address at the same edge.
- MemRead and MemWrite in the same cycle to the same word: read-before-write. ReadData returns the old contents, and the write takes effect at the same edge.
- Back-to-back store then load to the same word: the load sees the new data.
- Loads every cycle: one result per cycle, no stall, no bubbles.
- Reset asserted mid-load: the pending ReadValid is cancelled and outputs take their reset values. RAM keeps any write from completed edges.
- Address wrap: the offset subtraction is unsigned. Address < BASE_ADDR must be flagged, never aliased.

Test Plan:
- Store word 32'hDEADBEEF @0x1001_0000, then load word with Unsigned=0 -> next cycle ReadData=32'hDEADBEEF, ReadValid=1 for one cycle.
- Store byte 8'h80 @0x1001_0006, then load byte signed -> ReadData=32'hFFFF_FF80. Load unsigned -> 32'h0000_0080. Load word @0x1001_0004 -> 32'h0080_0000 (other lanes preloaded 0).
- Store half 16'h8001 @0x1001_000A, then load half signed -> 32'hFFFF_8001. A load half @0x1001_0009 -> ReadData=0, AccessError pulse, ErrorSticky=1, ErrorAddr=0x1001_0009. A store word @0x1001_0002 leaves RAM unchanged.
- Out of range: load @0x1000_FFFC and @BASE+4*MEMORY_DEPTH -> AccessError each; a store there does not corrupt word 0 (readback unchanged).
- Simultaneous MemRead+MemWrite word @0x1001_0010 (old 0x1111_1111, new 0x2222_2222) -> ReadData=0x1111_1111; next load returns 0x2222_2222.
- Assert reset=0 the cycle after a load request -> ReadValid stays 0, outputs 0, ErrorSticky cleared. Subsequent load returns the pre-reset stored data.
